fetch_unit: RTL and testbench

//   Requesting end of the i-cache read interface: generates the PC stream, drives en/addr

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 77 +++++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched {pc,instr} entries, flush beats push
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head mux below hides stale contents when empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        count = count_q;
        if (count_q != '0) begin
            head = mem_q[rd_ptr_q];
        end else begin
            head.pc    = '0;
            head.instr = NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, icache request/response capture and fetch queue
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ic_en,
    output logic [31:0] ic_addr,
    input  logic [31:0] ic_rdata,
    input  logic        ic_rvalid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        err_spurious
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FQ_DEPTH);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         inflight_q, inflight_d;
    logic         kill_q, kill_d;
    logic         err_q, err_d;
    fetch_state_e state_q, state_d;

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        // Credits use registered occupancy only, so out_ready never reaches ic_en.
        credit_ok    = (count + {{(CW - 1){1'b0}}, inflight_q}) < DEPTH_CNT;
        ic_en        = !rst && !redirect_valid && credit_ok;
        ic_addr      = pc_q;
        out_valid    = (count != '0);
        out_pc       = head.pc;
        out_instr    = head.instr;
        err_spurious = err_q;
        pop          = out_valid && out_ready;
        push         = ic_rvalid && inflight_q && !kill_q && !redirect_valid;
        push_entry.pc    = inflight_pc_q;
        push_entry.instr = ic_rdata;

        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        kill_d        = 1'b0;
        err_d         = err_q | (ic_rvalid && !inflight_q && !kill_q);
        state_d       = state_q;

        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            kill_d     = inflight_q;
            inflight_d = 1'b0;
            state_d    = inflight_q ? FLUSH : RUN;
        end else begin
            inflight_d = ic_en;
            if (ic_en) begin
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end
            case (state_q)
                FLUSH:   state_d = RUN;
                default: state_d = credit_ok ? RUN : STALL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
            err_q         <= 1'b0;
            state_q       <= RUN;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
            err_q         <= err_d;
            state_q       <= state_d;
        end
    end

    fetch_queue #(
        .DEPTH(FQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit with an icache model
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ic_en;
    logic [31:0] ic_addr;
    logic [31:0] ic_rdata;
    logic        ic_rvalid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        err_spurious;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [256];
    bit          resp_pend;
    logic [31:0] resp_addr;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    bit          m_infl;
    bit          m_kill;
    bit          m_err;

    int          en_pulses;
    bit          last_en;
    bit          last_ov;
    logic [31:0] last_addr;
    logic [31:0] last_opc;
    bit          popped;
    logic [31:0] pop_pc;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .FQ_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ic_en         (ic_en),
        .ic_addr       (ic_addr),
        .ic_rdata      (ic_rdata),
        .ic_rvalid     (ic_rvalid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .err_spurious  (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_pc      = 32'h0;
        m_ipc     = 32'h0;
        m_infl    = 0;
        m_kill    = 0;
        m_err     = 0;
        resp_pend = 0;
    endtask

    // One clock cycle, entered and left on the falling edge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit spur);
        bit          exp_en;
        bit          exp_ov;
        logic [31:0] exp_pc;
        logic [31:0] exp_in;
        bit          rv;
        ent_t        e;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = rdy;
        rv             = resp_pend | spur;
        ic_rvalid      = rv;
        ic_rdata       = resp_pend ? mem[resp_addr[9:2]] : $urandom;
        #1;
        exp_en = !redir && ((m_q.size() + int'(m_infl)) < DEPTH);
        exp_ov = (m_q.size() != 0);
        exp_pc = exp_ov ? m_q[0].pc : 32'h0;
        exp_in = exp_ov ? m_q[0].instr : NOP;
        total += 6;
        if (ic_en !== exp_en) begin
            bad++; $display("FAIL ic_en t=%0t got=%b want=%b", $time, ic_en, exp_en);
        end
        if (ic_addr !== m_pc) begin
            bad++; $display("FAIL ic_addr t=%0t got=%h want=%h", $time, ic_addr, m_pc);
        end
        if (out_valid !== exp_ov) begin
            bad++; $display("FAIL out_valid t=%0t got=%b want=%b", $time, out_valid, exp_ov);
        end
        if (out_pc !== exp_pc) begin
            bad++; $display("FAIL out_pc t=%0t got=%h want=%h", $time, out_pc, exp_pc);
        end
        if (out_instr !== exp_in) begin
            bad++; $display("FAIL out_instr t=%0t got=%h want=%h", $time, out_instr, exp_in);
        end
        if (err_spurious !== m_err) begin
            bad++; $display("FAIL err_spurious t=%0t got=%b want=%b", $time, err_spurious, m_err);
        end
        last_en   = ic_en;
        last_ov   = out_valid;
        last_addr = ic_addr;
        last_opc  = out_pc;
        popped    = out_valid && rdy;
        if (popped) pop_pc = out_pc;
        if (ic_en === 1'b1) en_pulses++;

        if (exp_ov && rdy) void'(m_q.pop_front());
        if (rv && m_infl && !m_kill && !redir) begin
            e.pc = m_ipc; e.instr = ic_rdata;
            m_q.push_back(e);
        end
        if (rv && !m_infl && !m_kill) m_err = 1;
        if (redir) begin
            m_q.delete();
            m_pc   = rpc & ~32'h3;
            m_kill = m_infl;
            m_infl = 0;
        end else begin
            m_kill = 0;
            m_infl = exp_en;
            if (exp_en) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
        end
        resp_pend = (ic_en === 1'b1);
        resp_addr = ic_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        total += 6;
        if (ic_en !== 1'b0) begin bad++; $display("FAIL %s ic_en got=%b want=0", tag, ic_en); end
        if (ic_addr !== 32'h0) begin bad++; $display("FAIL %s ic_addr got=%h want=0", tag, ic_addr); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL %s out_valid got=%b want=0", tag, out_valid); end
        if (out_pc !== 32'h0) begin bad++; $display("FAIL %s out_pc got=%h want=0", tag, out_pc); end
        if (out_instr !== NOP) begin bad++; $display("FAIL %s out_instr got=%h want=%h", tag, out_instr, NOP); end
        if (err_spurious !== 1'b0) begin bad++; $display("FAIL %s err got=%b want=0", tag, err_spurious); end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        ic_rvalid = 0; ic_rdata = 0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 0);
            total++;
            if (last_addr !== 32'(4 * i)) begin
                bad++; $display("FAIL stream_addr i=%0d got=%h want=%h", i, last_addr, 4 * i);
            end
            if (i == 2) begin
                total++;
                if (!(last_ov === 1'b1 && last_opc === 32'h0)) begin
                    bad++; $display("FAIL stream_first got_valid=%b pc=%h want_valid=1 pc=0", last_ov, last_opc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        step(1, 32'h100, 0, 0);
        en_pulses = 0;
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        total += 2;
        if (en_pulses != DEPTH) begin bad++; $display("FAIL bp_pulses got=%0d want=%0d", en_pulses, DEPTH); end
        if (last_en !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b want=0", last_en); end
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        total++;
        if (last_en !== 1'b1) begin bad++; $display("FAIL bp_resume got=%b want=1", last_en); end
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    endtask

    task automatic test_redirect();
        int n = 0;
        step(1, 32'h0, 1, 0);
        while (!(m_infl && m_ipc == 32'h10) && n < 20) begin
            step(0, 0, 1, 0);
            n++;
        end
        total++;
        if (n >= 20) begin bad++; $display("FAIL redir_setup timeout got=%0d want<20", n); end
        step(1, 32'h40, 1, 0);
        step(0, 0, 1, 0);
        total += 3;
        if (last_en !== 1'b1) begin bad++; $display("FAIL redir_en got=%b want=1", last_en); end
        if (last_addr !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h want=40", last_addr); end
        if (last_ov !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b want=0", last_ov); end
        n = 0; popped = 0;
        while (!popped && n < 10) begin step(0, 0, 1, 0); n++; end
        total++;
        if (!popped || pop_pc !== 32'h40) begin
            bad++; $display("FAIL redir_first got=%h want=40", pop_pc);
        end
    endtask

    task automatic test_consecutive();
        int n = 0;
        step(1, 32'h43, 1, 0);
        step(0, 0, 1, 0);
        total++;
        if (last_addr !== 32'h40) begin bad++; $display("FAIL align got=%h want=40", last_addr); end
        step(0, 0, 1, 0);
        step(1, 32'h80, 1, 0);
        step(1, 32'hC0, 1, 0);
        popped = 0;
        while (!popped && n < 10) begin step(0, 0, 1, 0); n++; end
        total++;
        if (!popped || pop_pc !== 32'hC0) begin
            bad++; $display("FAIL double_redir got=%h want=c0", pop_pc);
        end
    endtask

    task automatic test_spurious();
        step(1, 32'h200, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        total++;
        if (err_spurious !== 1'b1) begin bad++; $display("FAIL spurious got=%b want=1", err_spurious); end
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        total++;
        if (err_spurious !== 1'b1) begin bad++; $display("FAIL spurious_sticky got=%b want=1", err_spurious); end
    endtask

    task automatic test_wrap_and_async_reset();
        step(1, 32'hFFFF_FFFC, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        total++;
        if (last_addr !== 32'h0) begin bad++; $display("FAIL wrap got=%h want=0", last_addr); end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        ic_rvalid = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    endtask

    task automatic test_random();
        bit          rd;
        bit          rdy;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            rd  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = $urandom;
            step(rd, rpc, rdy, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_consecutive();
        test_spurious();
        test_wrap_and_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
